// File: rtl/detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : detector_pkg
// Description : Shared types for the detect/report block: FSM state encoding,
//               the captured-record structure, the default round-counter
//               width and a small multi-hot helper used for tie detection.
// Revision    : 1.0 - initial release
// ============================================================================
package detector_pkg;

    // Default width of the round cycle counter.
    localparam int CNT_W_DEF = 16;

    // Storage width of the cycles field inside the record. The top level
    // only exposes the low CNT_W bits and refuses CNT_W above this value.
    localparam int REC_CYCLES_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]              mask;
        logic [REC_CYCLES_W-1:0] cycles;
        logic                    tie;
        logic                    timeout;
    } rec_t;

    // True when two or more of the three detector bits are set.
    function automatic logic is_multi_hot3(input logic [2:0] m);
        return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_timer.sv
`default_nettype none
// ============================================================================
// Module      : round_timer
// Description : Round cycle counter. Synchronous clear has priority over
//               enable; hit flags that the count sits at TIMEOUT-1, i.e. the
//               current cycle is the last one before the round times out.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-low reset
//               clear  - zero the counter on the next edge
//               enable - increment the counter on the next edge
//               count  - current count value
//               hit    - count == TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module round_timer
    import detector_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (count_q == HIT_VAL);

endmodule
`default_nettype wire

// File: rtl/detect_reporter.sv
`default_nettype none
// ============================================================================
// Module      : detect_reporter
// Description : Runs one detection round at a time. A start request holds
//               the detector in reset for ARM_CYCLES cycles, then releases
//               it and counts cycles until the detector reports a non-zero
//               mask or TIMEOUT cycles elapse. The outcome is published as a
//               valid/ready record; the detector stays released (and thus
//               locked on its result) until the record is accepted.
// Ports       : clk         - rising-edge clock
//               rst         - asynchronous active-low reset
//               start       - one-cycle round request (honoured in IDLE only)
//               abort       - cancel a round in ARM or WAIT
//               y_in[2:0]   - locked first-signal mask (bit0=a,1=b,2=c)
//               det_rst_n   - registered active-low detector reset
//               busy        - FSM is not IDLE
//               rec_valid   - record available
//               rec_ready   - consumer accepts the record
//               rec_mask    - captured winner mask
//               rec_cycles  - WAIT cycles elapsed before detection
//               rec_tie     - more than one bit set in rec_mask
//               rec_timeout - round ended without a detection
// Revision    : 1.0 - initial release
// ============================================================================
module detect_reporter
    import detector_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TIMEOUT    = 1000,
    parameter int ARM_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       y_in,
    output logic             det_rst_n,
    output logic             busy,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [2:0]       rec_mask,
    output logic [CNT_W-1:0] rec_cycles,
    output logic             rec_tie,
    output logic             rec_timeout
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    localparam longint TIMEOUT_MAX = (longint'(1) << CNT_W) - 1;

    if ((CNT_W < 1) || (CNT_W > REC_CYCLES_W)) begin : g_bad_cnt_w
        $error("detect_reporter: CNT_W out of range");
    end
    if ((TIMEOUT < 1) || (longint'(TIMEOUT) > TIMEOUT_MAX)) begin : g_bad_timeout
        $error("detect_reporter: TIMEOUT out of range");
    end
    if (ARM_CYCLES < 1) begin : g_bad_arm_cycles
        $error("detect_reporter: ARM_CYCLES must be at least 1");
    end

    // ARM counter runs 0..ARM_CYCLES-1.
    localparam int                      ARM_W       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0]        ARM_LAST    = ARM_W'(ARM_CYCLES - 1);
    localparam logic [REC_CYCLES_W-1:0] TIMEOUT_VAL = REC_CYCLES_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [ARM_W-1:0] arm_cnt_q;
    logic [ARM_W-1:0] arm_cnt_d;
    rec_t             rec_q;
    rec_t             rec_d;
    logic             rec_valid_q;
    logic             rec_valid_d;
    logic             det_rst_n_q;
    logic             det_rst_n_d;

    logic             timer_clear;
    logic             timer_en;
    logic [CNT_W-1:0] timer_count;
    logic             timer_hit;

    round_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_round_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .count  (timer_count),
        .hit    (timer_hit)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        rec_d       = rec_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start beats a simultaneous abort because abort means
                // nothing in IDLE.
                if (start) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = '0;
                end
            end

            ST_ARM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d     = ST_WAIT;
                    timer_clear = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end

            ST_WAIT: begin
                timer_en = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (y_in != 3'b000) begin
                    // Detection is checked first so it wins over a
                    // coincident timeout.
                    rec_d.mask    = y_in;
                    rec_d.cycles  = REC_CYCLES_W'(timer_count);
                    rec_d.tie     = is_multi_hot3(y_in);
                    rec_d.timeout = 1'b0;
                    state_d       = ST_REPORT;
                end else if (timer_hit) begin
                    rec_d.mask    = 3'b000;
                    rec_d.cycles  = TIMEOUT_VAL;
                    rec_d.tie     = 1'b0;
                    rec_d.timeout = 1'b1;
                    state_d       = ST_REPORT;
                end
            end

            ST_REPORT: begin
                // Record fields are untouched here, so they hold steady
                // under backpressure.
                if (rec_valid_q && rec_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Both outputs are registered copies of the next-state decode so
        // they line up with the state register.
        rec_valid_d = (state_d == ST_REPORT);
        det_rst_n_d = (state_d == ST_WAIT) || (state_d == ST_REPORT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            arm_cnt_q   <= '0;
            rec_q       <= '0;
            rec_valid_q <= 1'b0;
            det_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            rec_q       <= rec_d;
            rec_valid_q <= rec_valid_d;
            det_rst_n_q <= det_rst_n_d;
        end
    end

    // Upper record bits beyond CNT_W are always zero and never exposed.
    if (CNT_W < REC_CYCLES_W) begin : g_rec_hi_unused
        logic unused_rec_hi;
        assign unused_rec_hi = ^rec_q.cycles[REC_CYCLES_W-1:CNT_W];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign det_rst_n   = det_rst_n_q;
    assign busy        = (state_q != ST_IDLE);
    assign rec_valid   = rec_valid_q;
    assign rec_mask    = rec_q.mask;
    assign rec_cycles  = rec_q.cycles[CNT_W-1:0];
    assign rec_tie     = rec_q.tie;
    assign rec_timeout = rec_q.timeout;

endmodule
`default_nettype wire

// File: tb/tb_detect_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_detect_reporter
// Description : Directed self-checking bench for detect_reporter with
//               TIMEOUT=16 and ARM_CYCLES=2. Inputs change 1 ns after a
//               rising edge and outputs are checked at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detect_reporter;

    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 16;
    localparam int ARM_CYCLES = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [2:0]       y_in;
    logic             det_rst_n;
    logic             busy;
    logic             rec_valid;
    logic             rec_ready;
    logic [2:0]       rec_mask;
    logic [CNT_W-1:0] rec_cycles;
    logic             rec_tie;
    logic             rec_timeout;

    int n_total = 0;
    int n_bad   = 0;

    detect_reporter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .ARM_CYCLES (ARM_CYCLES)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .y_in        (y_in),
        .det_rst_n   (det_rst_n),
        .busy        (busy),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_mask    (rec_mask),
        .rec_cycles  (rec_cycles),
        .rec_tie     (rec_tie),
        .rec_timeout (rec_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from IDLE and step to the first WAIT cycle (counter 0),
    // checking the detector reset stays low for the two ARM cycles.
    task automatic start_round(input string pfx);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({pfx, ".arm1_busy"}, 32'(busy), 32'd1);
        chk({pfx, ".arm1_drst"}, 32'(det_rst_n), 32'd0);
        tick();
        chk({pfx, ".arm2_drst"}, 32'(det_rst_n), 32'd0);
        tick();
        chk({pfx, ".wait_drst"}, 32'(det_rst_n), 32'd1);
    endtask

    task automatic chk_rec(input string pfx, input logic [2:0] m, input int cyc,
                           input logic tie, input logic to);
        chk({pfx, ".valid"},   32'(rec_valid),   32'd1);
        chk({pfx, ".mask"},    32'(rec_mask),    32'(m));
        chk({pfx, ".cycles"},  32'(rec_cycles),  32'(cyc));
        chk({pfx, ".tie"},     32'(rec_tie),     32'(tie));
        chk({pfx, ".timeout"}, 32'(rec_timeout), 32'(to));
    endtask

    task automatic accept(input string pfx);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        y_in      = 3'b000;
        chk({pfx, ".acc_valid"}, 32'(rec_valid), 32'd0);
        chk({pfx, ".acc_busy"},  32'(busy),      32'd0);
        chk({pfx, ".acc_drst"},  32'(det_rst_n), 32'd0);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        y_in      = 3'b000;
        rec_ready = 1'b0;

        // ---------------- reset state ----------------
        #3;
        chk("rst.drst",    32'(det_rst_n),   32'd0);
        chk("rst.busy",    32'(busy),        32'd0);
        chk("rst.valid",   32'(rec_valid),   32'd0);
        chk("rst.mask",    32'(rec_mask),    32'd0);
        chk("rst.cycles",  32'(rec_cycles),  32'd0);
        chk("rst.tie",     32'(rec_tie),     32'd0);
        chk("rst.timeout", 32'(rec_timeout), 32'd0);
        tick();
        tick();
        rst       = 1'b1;
        rec_ready = 1'b1;   // ignored: no record pending
        wait_ticks(3);
        rec_ready = 1'b0;
        chk("post_rst.busy",  32'(busy),      32'd0);
        chk("post_rst.valid", 32'(rec_valid), 32'd0);

        // ---------------- detection on 5th WAIT cycle ----------------
        start_round("det5");
        wait_ticks(4);
        chk("det5.pre_valid", 32'(rec_valid), 32'd0);
        y_in = 3'b001;
        tick();
        chk_rec("det5", 3'b001, 4, 1'b0, 1'b0);
        chk("det5.rep_drst", 32'(det_rst_n), 32'd1);
        accept("det5");

        // ---------------- tie patterns ----------------
        start_round("tie6");
        y_in = 3'b110;
        tick();
        chk_rec("tie6", 3'b110, 0, 1'b1, 1'b0);
        accept("tie6");

        start_round("tie7");
        wait_ticks(2);
        y_in = 3'b111;
        tick();
        chk_rec("tie7", 3'b111, 2, 1'b1, 1'b0);
        accept("tie7");

        // ---------------- timeout ----------------
        start_round("tmo");
        wait_ticks(15);
        chk("tmo.pre_valid", 32'(rec_valid), 32'd0);
        chk("tmo.pre_busy",  32'(busy),      32'd1);
        tick();
        chk_rec("tmo", 3'b000, 16, 1'b0, 1'b1);
        accept("tmo");

        // ---------------- detection on the timeout edge ----------------
        start_round("tmo_det");
        wait_ticks(15);
        y_in = 3'b010;
        tick();
        chk_rec("tmo_det", 3'b010, 15, 1'b0, 1'b0);
        accept("tmo_det");

        // ---------------- backpressure with start pulse ----------------
        start_round("bp");
        wait_ticks(3);
        y_in = 3'b100;
        tick();
        chk_rec("bp.rise", 3'b100, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            tick();
            start = 1'b0;
            chk_rec("bp.hold", 3'b100, 3, 1'b0, 1'b0);
            chk("bp.hold_drst", 32'(det_rst_n), 32'd1);
            chk("bp.hold_busy", 32'(busy),      32'd1);
        end
        accept("bp");
        tick();
        chk("bp.no_new_round", 32'(busy), 32'd0);

        // ---------------- abort during WAIT ----------------
        start_round("abw");
        wait_ticks(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abw.busy", 32'(busy),      32'd0);
        chk("abw.drst", 32'(det_rst_n), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abw.no_valid", 32'(rec_valid), 32'd0);
        end

        // ---------------- abort during ARM ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("aba.busy", 32'(busy), 32'd0);

        // ---------------- start and abort together in IDLE ----------------
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa.busy", 32'(busy),      32'd1);
        chk("sa.drst", 32'(det_rst_n), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("sa.abort_busy", 32'(busy), 32'd0);

        // ---------------- async reset during REPORT ----------------
        start_round("rr");
        y_in = 3'b011;
        tick();
        chk_rec("rr", 3'b011, 0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rr.drst",    32'(det_rst_n),   32'd0);
        chk("rr.busy",    32'(busy),        32'd0);
        chk("rr.valid",   32'(rec_valid),   32'd0);
        chk("rr.mask",    32'(rec_mask),    32'd0);
        chk("rr.cycles",  32'(rec_cycles),  32'd0);
        chk("rr.tie",     32'(rec_tie),     32'd0);
        chk("rr.timeout", 32'(rec_timeout), 32'd0);
        tick();
        rst  = 1'b1;
        y_in = 3'b000;
        wait_ticks(3);
        chk("rr.idle_busy", 32'(busy),      32'd0);
        chk("rr.idle_drst", 32'(det_rst_n), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/detect_reporter.md
DETECT_REPORTER -- requirements
Module: detect_reporter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low, with ports named clk and rst as elsewhere in the codebase.
REQ-002 Parameter CNT_W, default 16, SHALL be the round cycle-counter width.
REQ-003 Parameter TIMEOUT, default 1000, SHALL be the number of WAIT cycles before a round is declared empty; legal range 1..2^CNT_W-1.
REQ-004 Parameter ARM_CYCLES, default 2, SHALL be the minimum detector-reset low time after start; legal range >=1.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: one-cycle request to begin a round.
REQ-008 Port abort, input, 1: cancels a round in ARM or WAIT.
REQ-009 Port y_in, input, 3: locked first-signal mask from the detector stage (bit0=a, bit1=b, bit2=c).
REQ-010 Port det_rst_n, output, 1: registered active-low reset to the detector.
REQ-011 Port busy, output, 1: high whenever state is not IDLE.
REQ-012 Port rec_valid, output, 1: record available.
REQ-013 Port rec_ready, input, 1: consumer accepts the record.
REQ-014 Port rec_mask, output, 3: captured winner mask.
REQ-015 Port rec_cycles, output, CNT_W: WAIT cycles elapsed before detection.
REQ-016 Port rec_tie, output, 1: more than one bit set in rec_mask.
REQ-017 Port rec_timeout, output, 1: round ended with no detection.

Function
REQ-018 The FSM SHALL have states IDLE, ARM, WAIT and REPORT.
REQ-019 IDLE -> ARM SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-020 det_rst_n SHALL be 0 in IDLE and ARM, and 1 in WAIT and REPORT, so the detector stays locked until the record is accepted.
REQ-021 The FSM SHALL remain in ARM for exactly ARM_CYCLES cycles, then enter WAIT with the counter cleared to 0.
REQ-022 In WAIT, the counter SHALL increment once per cycle.
REQ-023 At a WAIT clock edge with y_in!=0, the block SHALL capture rec_mask=y_in, rec_cycles=counter, rec_tie=(popcount(y_in)>1) and rec_timeout=0, then go to REPORT.
REQ-024 At a WAIT edge with y_in==0 and counter==TIMEOUT-1, the block SHALL capture rec_mask=0, rec_cycles=TIMEOUT, rec_tie=0 and rec_timeout=1, then go to REPORT.
REQ-025 If detection and timeout coincide on the same edge, detection SHALL win.
REQ-026 rec_valid SHALL be asserted from the first REPORT cycle (one cycle after capture) and held until the cycle in which rec_valid&&rec_ready is sampled; the FSM then goes to IDLE.
REQ-027 All rec_* fields SHALL remain stable while rec_valid=1 and rec_ready=0.
REQ-028 In ARM or WAIT, abort=1 SHALL return the FSM to IDLE with no record produced; abort SHALL be ignored in IDLE and REPORT.
REQ-029 If start and abort are both high in IDLE, the FSM SHALL enter ARM.
REQ-030 rec_ready SHALL be ignored when rec_valid=0.

Reset
REQ-031 Asserting rst (low) SHALL immediately force: state=IDLE, det_rst_n=0, busy=0, rec_valid=0, rec_mask=0, rec_cycles=0, rec_tie=0, rec_timeout=0 and counter=0, at any point including mid-round and mid-handshake.
REQ-032 After rst deasserts, the block SHALL take no action until the first start.

Structure
REQ-033 A shared package detector_pkg SHALL hold the FSM state enum, a record struct (mask, cycles, tie, timeout) and the default CNT_W constant.
REQ-034 The cycle counter SHALL be a sub-module named round_timer, with clear, enable, count and hit(TIMEOUT-1) signals.
REQ-035 Illegal parameter values SHALL be rejected at elaboration.

Verification (TIMEOUT=16, ARM_CYCLES=2)
REQ-036 Scenario: start; y_in=001 driven at the 5th WAIT cycle -> det_rst_n low for 2 cycles after start; record mask=001, cycles=4, tie=0, timeout=0.
REQ-037 Scenario: start; y_in=110 -> record mask=110, tie=1; y_in=111 -> record mask=111, tie=1.
REQ-038 Scenario: start; y_in held at 000 -> record mask=000, cycles=16, timeout=1; y_in=010 on the timeout edge -> record mask=010, timeout=0.
REQ-039 Scenario: rec_ready low for 5 cycles after rec_valid rises, with start pulsed -> fields stable, det_rst_n=1, no new round; accepted on the 6th cycle -> IDLE, det_rst_n=0.
REQ-040 Scenario: abort during WAIT -> IDLE next cycle, rec_valid never asserted; rst low during REPORT -> all outputs at reset values asynchronously.
